// File: rtl/spi_pkg.sv
// Shared types for the SPI master feed path: byte width, feeder FSM states, FIFO entry layout.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD,
    ST_GUARD
  } fsm_state_e;

  typedef struct packed {
    logic                  last;
    logic [SPI_BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Small synchronous FIFO of {last, data} entries; head is always visible on o_rdata.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  fifo_entry_t      i_wdata,
  input  logic             i_pop,
  output fifo_entry_t      o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  fifo_entry_t      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_feeder.sv
// Feeds queued bytes to an SPI master shifter one at a time, framing bursts with active-low cs
// and honouring setup time before the first load and a guard gap between frames.
module spi_frame_feeder
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SPI_BYTE_W-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [SPI_BYTE_W-1:0] p_data_in,
  output logic                  p_load,
  input  logic                  p_done,
  output logic                  cs,
  output logic                  busy
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TMR_W   = $clog2(SETUP_CYCLES + GUARD_CYCLES + 1);

  fsm_state_e            r_state;
  fsm_state_e            w_state_nxt;
  logic [TMR_W-1:0]      r_tmr;
  logic [TMR_W-1:0]      w_tmr_nxt;
  logic [BURST_W-1:0]    r_burst;
  logic [BURST_W-1:0]    w_burst_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic                  r_cs;
  logic                  w_cs_nxt;
  logic                  r_load;
  logic                  w_load_nxt;
  logic [SPI_BYTE_W-1:0] r_data;
  logic [SPI_BYTE_W-1:0] w_data_nxt;

  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  fifo_entry_t           w_head;
  fifo_entry_t           w_wdata;

  assign s_ready   = reset & ~w_full;
  assign w_wdata   = '{last: s_last, data: s_data};
  assign busy      = (r_state != ST_IDLE) | (w_count != '0);
  assign cs        = r_cs;
  assign p_load    = r_load;
  assign p_data_in = r_data;

  spi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (s_valid & s_ready),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state and registered-output decode; a pop always coincides with a load strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_burst_nxt = r_burst;
    w_last_nxt  = r_last;
    w_cs_nxt    = r_cs;
    w_load_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cs_nxt = 1'b1;
        if (!w_empty) begin
          w_cs_nxt    = 1'b0;
          w_tmr_nxt   = '0;
          w_burst_nxt = '0;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_tmr == TMR_W'(SETUP_CYCLES - 1)) begin
          w_pop       = 1'b1;
          w_load_nxt  = 1'b1;
          w_data_nxt  = w_head.data;
          w_last_nxt  = w_head.last;
          w_state_nxt = ST_LOAD;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_LOAD: begin
        w_burst_nxt = r_burst + BURST_W'(1);
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (p_done) begin
          if (r_last || (r_burst == BURST_W'(MAX_BURST))) begin
            w_cs_nxt    = 1'b1;
            w_tmr_nxt   = '0;
            w_state_nxt = ST_GUARD;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_load_nxt  = 1'b1;
            w_data_nxt  = w_head.data;
            w_last_nxt  = w_head.last;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load_nxt  = 1'b1;
          w_data_nxt  = w_head.data;
          w_last_nxt  = w_head.last;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_GUARD: begin
        if (r_tmr == TMR_W'(GUARD_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_cs_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_burst <= '0;
      r_last  <= 1'b0;
      r_cs    <= 1'b1;
      r_load  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_burst <= w_burst_nxt;
      r_last  <= w_last_nxt;
      r_cs    <= w_cs_nxt;
      r_load  <= w_load_nxt;
      r_data  <= w_data_nxt;
    end
  end

endmodule

// File: doc/spi_frame_feeder.md
Name: spi_frame_feeder

Overview:
- Upstream stage of the SPI master shifter (spi_module with p_master=1).
- Accepts a byte stream on a valid/ready interface and buffers it in a small FIFO.
- Frames bursts of bytes with chip-select (active low).
- Presents one byte at a time on the shifter's parallel input with a load strobe, and waits for the shifter's done pulse before presenting the next.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- SETUP_CYCLES, 2, clocks from cs falling to the first p_load of a frame (>=1).
- GUARD_CYCLES, 2, minimum clocks cs stays high between frames (>=1).
- MAX_BURST, 16, maximum bytes per frame; cs is forced high after this many bytes even without s_last.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  8  byte to transmit.
- s_last  in  1  marks the final byte of a frame.
- s_valid  in  1  s_data/s_last valid.
- s_ready  out  1  FIFO can accept; equals reset & !full (combinational).
- p_data_in  out  8  byte to the shifter; registered; held stable between loads.
- p_load  out  1  one-clock registered strobe: shifter captures p_data_in.
- p_done  in  1  one-clock pulse from the shifter: current byte fully shifted.
- cs  out  1  chip select, active low, registered.
- busy  out  1  high whenever state != IDLE or the FIFO is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - cs=1, p_load=0, p_data_in=8'h00.
  - FIFO flushed; burst count 0; state IDLE; s_ready=0.
  - Applying reset mid-frame raises cs immediately and discards all queued bytes.
- FIFO: 9-bit entries {last, data}; push on s_valid & s_ready.
  - No bypass. A push into a full FIFO cannot occur (s_ready=0).
  - Push and pop on the same edge are both performed; occupancy is unchanged.
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD, GUARD.
  - IDLE: cs=1. If the FIFO is non-empty at an edge: cs<=0, setup counter<=0, burst count<=0, go to SETUP.
  - SETUP: the counter increments each edge. After SETUP_CYCLES edges in SETUP, go to LOAD with p_load<=1 on that edge; the byte is popped and p_data_in<=head data.
    - Net effect: if cs falls at edge E, then p_load is high for exactly the cycle after edge E+SETUP_CYCLES.
  - LOAD: single cycle; p_load<=0; burst count+1; the last flag of the popped byte is latched; go to WAIT.
  - WAIT: wait for p_done; p_done outside WAIT is ignored. On p_done:
    - If the latched last=1 or burst count==MAX_BURST: cs<=1, go to GUARD.
    - Else if the FIFO is non-empty: p_load<=1 with a pop, go to LOAD (back-to-back, no extra gap).
    - Else go to HOLD.
  - HOLD: cs stays 0 indefinitely. When the FIFO becomes non-empty, p_load<=1 with a pop, go to LOAD.
  - GUARD: cs=1 for GUARD_CYCLES edges, then IDLE. A non-empty FIFO then starts a new frame at the next edge.
- Burst counter width: $clog2(MAX_BURST+1); it never wraps because the frame ends at MAX_BURST.
- A byte with s_last=1 arriving while cs is low ends the current frame after that byte.
- cs never toggles between p_load and its matching p_done.

Decomposition:
- Shared package spi_pkg:
  - SPI_BYTE_W=8.
  - fsm state enum (IDLE, SETUP, LOAD, WAIT, HOLD, GUARD).
  - FIFO entry struct {last, data}.
- One sub-module: spi_byte_fifo.
  - Parameterised DEPTH; ports push/pop/full/empty/count.
  - Asynchronous active-low reset on the same reset.
- The FSM and counters live in spi_frame_feeder.

Test Plan:
1. Single byte 8'hE9 with s_last=1 pushed into an empty FIFO; bench returns p_done 16 clocks after p_load.
   - Required: cs falls one edge after the push.
   - Required: p_load pulses once, SETUP_CYCLES=2 edges later, with p_data_in=8'hE9.
   - Required: cs rises on the p_done edge and stays high >=2 clocks; busy then returns to 0.
2. Three bytes 8'h01, 8'h02, 8'h03 (last on 03) pushed back-to-back.
   - Required: one cs-low frame with three p_load pulses, each on the edge after the preceding p_done.
   - Required: p_data_in sequence 01, 02, 03; cs rises after the third p_done.
3. Byte 8'hA5 (no last) pushed; 20 clocks after its p_done, push 8'h5A with last.
   - Required: cs held low throughout HOLD; 5A loaded on the edge after its push becomes visible; single frame.
4. DEPTH=4, 6 bytes offered while the shifter withholds p_done.
   - Required: s_ready=0 after 4 bytes are queued (1 popped into LOAD, so the 5th is accepted).
   - Required: no byte lost or duplicated; output order equals input order.
5. MAX_BURST=16 with 18 bytes, none marked last.
   - Required: cs rises after the 16th p_done and stays high 2 clocks.
   - Required: a new frame carries bytes 17-18, then enters HOLD with cs low.
6. reset driven low mid-WAIT.
   - Required: cs=1 and p_load=0 immediately (before the next clock); FIFO empty, s_ready=0 during reset, s_ready=1 after release.
   - Required: no p_load until new data is pushed.
